// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory-access stage: access-type encodings,
// FSM state type, zero word and the alignment rule.
package mem_access_pkg;

    typedef enum logic [2:0] {
        OP_LB  = 3'd0,
        OP_LH  = 3'd1,
        OP_LW  = 3'd2,
        OP_LBU = 3'd3,
        OP_LHU = 3'd4,
        OP_SB  = 3'd5,
        OP_SH  = 3'd6,
        OP_SW  = 3'd7
    } mem_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [31:0] ZERO_WORD = '0;

    // Word accesses need addr[1:0]==0, halfword accesses need addr[0]==0.
    function automatic logic misaligned(input logic [2:0] op, input logic [1:0] lane);
        logic bad;
        bad = 1'b0;
        case (op)
            OP_LW, OP_SW:         bad = (lane != 2'b00);
            OP_LH, OP_LHU, OP_SH: bad = lane[0];
            default:              bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_access_load_extend.sv
// Load lane selection and sign/zero extension of a captured bus word.
module load_extend
    import mem_access_pkg::*;
(
    input  logic [31:0] data,
    input  logic [1:0]  addr,
    input  logic [2:0]  mem_op,
    output logic [31:0] result
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // Pick the addressed byte/halfword (little-endian) and extend it.
    always_comb begin
        byte_lane = data[7:0];
        case (addr)
            2'd0: byte_lane = data[7:0];
            2'd1: byte_lane = data[15:8];
            2'd2: byte_lane = data[23:16];
            2'd3: byte_lane = data[31:24];
            default: byte_lane = data[7:0];
        endcase
        half_lane = addr[1] ? data[31:16] : data[15:0];
        case (mem_op)
            OP_LB:   result = {{24{byte_lane[7]}}, byte_lane};
            OP_LBU:  result = {24'd0, byte_lane};
            OP_LH:   result = {{16{half_lane[15]}}, half_lane};
            OP_LHU:  result = {16'd0, half_lane};
            default: result = data;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// MEM stage: issues one registered data-bus transaction per aligned load or
// store, stalls the pipeline while it is outstanding, times out a silent bus
// and formats load data for write-back.
module mem_access
    import mem_access_pkg::*;
#(
    parameter int BUS_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic [2:0]  MemOp_i,
    input  logic [31:0] MemAddr_i,
    input  logic [31:0] StoreData_i,
    input  logic [31:0] ALUResult_i,
    input  logic [4:0]  WriteRegDst_i,
    input  logic        RegWrite_i,
    input  logic        PipeStall_i,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    output logic [3:0]  bus_sel_o,
    input  logic        bus_ack_i,
    input  logic [31:0] bus_rdata_i,
    output logic [31:0] WriteRegData_o,
    output logic [4:0]  WriteRegDst_o,
    output logic        RegWrite_o,
    output logic        StallReq_o,
    output logic        AddrErr_o,
    output logic        BusErr_o
);

    localparam logic [15:0] TIMEOUT_LAST = 16'(BUS_TIMEOUT - 1);

    state_e      state;
    logic [31:0] rdata_q;
    logic [15:0] cnt;
    logic        err_q;
    logic        write_q;
    logic [2:0]  op_q;
    logic [1:0]  lane_q;

    logic        mem_op;
    logic        bad_align;
    logic [3:0]  sel_next;
    logic [31:0] wdata_next;
    logic [31:0] load_data;

    assign mem_op    = MemRead_i | MemWrite_i;
    assign bad_align = misaligned(MemOp_i, MemAddr_i[1:0]);

    // Byte-lane enables and replicated store data for the request being issued.
    always_comb begin
        sel_next   = 4'b1111;
        wdata_next = StoreData_i;
        case (MemOp_i)
            OP_SH: begin
                sel_next   = 4'b0011 << MemAddr_i[1:0];
                wdata_next = {2{StoreData_i[15:0]}};
            end
            OP_SB: begin
                sel_next   = 4'b0001 << MemAddr_i[1:0];
                wdata_next = {4{StoreData_i[7:0]}};
            end
            default: begin
                sel_next   = 4'b1111;
                wdata_next = StoreData_i;
            end
        endcase
    end

    // Access type and lane are latched at issue so DONE does not depend on
    // the upstream register still holding the instruction.
    load_extend u_load_extend (
        .data   (rdata_q),
        .addr   (lane_q),
        .mem_op (op_q),
        .result (load_data)
    );

    // Transaction FSM with registered bus request, capture and timeout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            bus_req_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_addr_o  <= ZERO_WORD;
            bus_wdata_o <= ZERO_WORD;
            bus_sel_o   <= '0;
            rdata_q     <= ZERO_WORD;
            cnt         <= '0;
            BusErr_o    <= 1'b0;
            err_q       <= 1'b0;
            write_q     <= 1'b0;
            op_q        <= '0;
            lane_q      <= '0;
        end else begin
            BusErr_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (mem_op && !bad_align) begin
                        state       <= BUS;
                        bus_req_o   <= 1'b1;
                        bus_we_o    <= MemWrite_i;
                        bus_addr_o  <= {MemAddr_i[31:2], 2'b00};
                        bus_sel_o   <= sel_next;
                        bus_wdata_o <= wdata_next;
                        cnt         <= '0;
                        err_q       <= 1'b0;
                        write_q     <= MemWrite_i;
                        op_q        <= MemOp_i;
                        lane_q      <= MemAddr_i[1:0];
                    end
                end
                BUS: begin
                    if (bus_ack_i) begin
                        rdata_q   <= bus_rdata_i;
                        bus_req_o <= 1'b0;
                        state     <= DONE;
                    end else if (cnt == TIMEOUT_LAST) begin
                        rdata_q   <= ZERO_WORD;
                        bus_req_o <= 1'b0;
                        BusErr_o  <= 1'b1;
                        err_q     <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                DONE: begin
                    if (!PipeStall_i) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Write-back selection, stall request and misalignment flag.
    always_comb begin
        WriteRegDst_o  = WriteRegDst_i;
        WriteRegData_o = ALUResult_i;
        RegWrite_o     = RegWrite_i;
        StallReq_o     = 1'b0;
        AddrErr_o      = 1'b0;
        case (state)
            IDLE: begin
                if (mem_op) begin
                    RegWrite_o = 1'b0;
                    if (bad_align) AddrErr_o  = 1'b1;
                    else           StallReq_o = 1'b1;
                end
            end
            BUS: begin
                RegWrite_o = 1'b0;
                StallReq_o = 1'b1;
            end
            DONE: begin
                if (write_q) begin
                    RegWrite_o = 1'b0;
                end else begin
                    WriteRegData_o = load_data;
                    RegWrite_o     = RegWrite_i & ~err_q;
                end
            end
            default: begin
                RegWrite_o = 1'b0;
            end
        endcase
    end

endmodule
